// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg.
// Carries the upstream side (in_valid/in_ready/in_ctrl/in_data), the flush
// request, and the downstream side (out_valid/out_ready/out_ctrl/out_data).
//   slave  : the skid register itself
//   master : the environment (upstream + downstream stages)
interface pipe_skid_reg_if #(
  parameter int unsigned DATA_W = 192,
  parameter int unsigned CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_ctrl, in_data, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

  modport master (
    output in_valid, in_ctrl, in_data, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-slot skid pipeline register between two instruction pipeline stages.
// The main slot drives the outputs; the skid slot absorbs one instruction when
// downstream stalls, so in_ready depends only on registered state.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   bus        - pipe_skid_reg_if.slave: in_* upstream handshake, flush,
//                out_* downstream handshake
//   stall_cnt  - (PIPE_SKID_REG_PERF_EN only) cycles with out_valid & !out_ready
//   bubble_cnt - (PIPE_SKID_REG_PERF_EN only) cycles with !out_valid & out_ready
// Optional feature macro: PIPE_SKID_REG_PERF_EN adds the saturating counters.
module pipe_skid_reg #(
  parameter int unsigned DATA_W = 192,
  parameter int unsigned CTRL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  pipe_skid_reg_if.slave     bus
`ifdef PIPE_SKID_REG_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        bubble_cnt
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic              in_fire, out_fire;

  // in_ready masked by reset so nothing is accepted while reset is held.
  assign bus.in_ready  = (state_q != StFull) & ~reset;
  assign bus.out_valid = (state_q != StEmpty);
  assign bus.out_ctrl  = main_ctrl_q;
  assign bus.out_data  = main_data_q;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (bus.flush) begin
      // Squash everything; main_data is left as-is (don't-care on a bubble).
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_ctrl_q <= bus.in_ctrl;
            main_data_q <= bus.in_data;
            state_q     <= StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_ctrl_q <= bus.in_ctrl;
            main_data_q <= bus.in_data;
          end else if (in_fire) begin
            skid_ctrl_q <= bus.in_ctrl;
            skid_data_q <= bus.in_data;
            state_q     <= StFull;
          end else if (out_fire) begin
            main_ctrl_q <= '0;  // bubble: control bits forced low
            state_q     <= StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
            state_q     <= StOne;
          end
        end
        default: begin
          state_q     <= StEmpty;
          main_ctrl_q <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_REG_PERF_EN
  // Saturating counters; only reset clears them, flush has no effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (bus.out_valid && !bus.out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (!bus.out_valid && bus.out_ready && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
- REQ-001 SHALL have parameter DATA_W, default 192, the payload width (operands, immediate, register addresses) carried without modification.
- REQ-002 SHALL have parameter CTRL_W, default 8, the control-bit width (ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, ...), forced to zero on a bubble.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
- REQ-005 SHALL have port in_valid, input, 1 bit: the upstream stage presents an instruction.
- REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an instruction this cycle.
- REQ-007 SHALL have port in_ctrl, input, CTRL_W bits: upstream control bits.
- REQ-008 SHALL have port in_data, input, DATA_W bits: upstream payload.
- REQ-009 SHALL have port flush, input, 1 bit: synchronous squash of all held and incoming instructions.
- REQ-010 SHALL have port out_valid, output, 1 bit: the downstream stage holds a valid instruction.
- REQ-011 SHALL have port out_ready, input, 1 bit: the downstream stage consumes the instruction.
- REQ-012 SHALL have port out_ctrl, output, CTRL_W bits: registered control bits.
- REQ-013 SHALL have port out_data, output, DATA_W bits: registered payload.

Function
- REQ-014 Handshake terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- REQ-015 Storage SHALL be two slots, main (drives the outputs) and skid, with states EMPTY, ONE and FULL.
- REQ-016 in_ready SHALL be 1 exactly when the state is not FULL and reset is deasserted; it SHALL be decoded from registered state, with no combinational path from out_ready.
- REQ-017 EMPTY: on in_fire, load main and go to ONE; otherwise stay in EMPTY.
- REQ-018 ONE: on in_fire with out_fire, reload main and stay in ONE.
- REQ-019 ONE: on in_fire without out_fire, load skid and go to FULL.
- REQ-020 ONE: on out_fire without in_fire, go to EMPTY; otherwise hold main.
- REQ-021 FULL: on out_fire, copy skid to main and go to ONE; otherwise hold both slots.
- REQ-022 Latency SHALL be 1 cycle: an instruction accepted at edge N appears on out_* after edge N when the block was EMPTY.
- REQ-023 Ordering SHALL be strict FIFO with no loss or duplication under any in_valid/out_ready pattern.
- REQ-024 out_valid SHALL be 1 in states ONE and FULL.
- REQ-025 out_ctrl SHALL be all-zero whenever out_valid is 0 (bubble); out_data is don't-care but SHALL hold its last value.
- REQ-026 Flush has highest priority: at the next edge the state SHALL be EMPTY, both slots invalid, and out_ctrl zero.
- REQ-027 An in_fire occurring in the same cycle as flush SHALL be discarded.
- REQ-028 An out_fire in the flush cycle SHALL still count as consumed downstream.
- REQ-029 Payload SHALL pass bit-exact, with no width conversion.

Reset
- REQ-030 While reset is high, the block SHALL be in state EMPTY, with out_valid=0, in_ready=0, out_ctrl=0, out_data=0 and the skid slot cleared.
- REQ-031 Reset SHALL take effect asynchronously, mid-transfer included; held instructions are lost.
- REQ-032 The first acceptance SHALL be possible on the first rising edge after reset deasserts.

Configuration
- REQ-033 Macro PIPE_SKID_REG_PERF_EN, when defined, SHALL add outputs stall_cnt[31:0] and bubble_cnt[31:0].
- REQ-034 stall_cnt SHALL increment each cycle with out_valid=1 and out_ready=0.
- REQ-035 bubble_cnt SHALL increment each cycle with out_valid=0 and out_ready=1.
- REQ-036 Both counters SHALL saturate at 0xFFFFFFFF, be cleared only by reset, and not be affected by flush.
- REQ-037 With PIPE_SKID_REG_PERF_EN undefined, the counter ports and logic SHALL be absent and all other behaviour SHALL be identical.

Verification
- REQ-038 Streaming: out_ready=1, in_valid=1 for 10 cycles with in_data=1..10 -> out_data=1..10 on consecutive cycles starting 1 cycle later; in_ready stays 1.
- REQ-039 Backpressure: ONE holding A, out_ready=0, B presented -> B accepted, FULL, in_ready=0; C held upstream; out_ready=1 -> A, then B, then C emerge in order.
- REQ-040 Bubble: in_valid=0 for 1 cycle with in_ctrl=8'hFF -> out_valid=0 and out_ctrl=8'h00 that cycle.
- REQ-041 Flush: FULL with A, B; flush=1 with in_valid=1 carrying C -> next cycle EMPTY, out_valid=0, C never appears.
- REQ-042 Async reset: reset pulsed mid-cycle while FULL -> outputs clear immediately without a clock edge; after release, first in_valid is accepted at the next edge.
- REQ-043 Counters (macro defined): 5 cycles out_valid=1 with out_ready=0 -> stall_cnt=5; then 3 idle cycles with out_ready=1 -> bubble_cnt=3; flush leaves both unchanged.
